led_cube_scan_driver: RTL and testbench
=======================================

// Module: led_cube_scan_driver
// PURPOSE
//  Parametrised N x N x N LED-cube driver: accepts frame bytes from a UART-fed byte stream,
//  assembles them into a double-buffered frame store and multiplexes the displayed frame
//  one layer at a time onto column/layer drive lines (GPIO header). Adds sync framing,
//  backpressure, tear-free frame swap and inter-layer blanking. Sits between the UART RX
//  path and the GPIO/LEDR/HEX conduits in the cube controller system.
// PARAMETERS
//  N            8       cube edge length; N*N must be a multiple of 8 (N = 4, 8, 12, ...)
//  LAYER_DWELL  50000   cycles each layer is lit (1 ms at 50 MHz); >= 1
//  BLANK_CYCLES 500     cycles all layers are off before each layer change; >= 1
//  SYNC_BYTE    8'hA5   frame header byte
// PORTS
//  clk          in   1      system clock (50 MHz)
//  reset_n      in   1      asynchronous active-low reset
//  enable       in   1      1 = scan runs; 0 = outputs dark, scan parked
//  in_data      in   8      frame byte from UART RX
//  in_valid     in   1      in_data valid
//  in_ready     out  1      byte accepted when in_valid & in_ready
//  col_out      out  N*N    column drive, active-high; bit r*N+c = row r, col c
//  layer_out    out  N      layer select, one-hot active-high; all-0 while blanked
//  frame_tick   out  1      1-cycle pulse when a new frame becomes visible
//  frame_count  out  8      frames made visible, wraps 255 -> 0 (HEX display)
//  sync_err     out  1      1-cycle pulse when a non-sync byte is discarded in L_SYNC
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready = 1; both buffers cleared; loader in L_SYNC,
//   scan in S_BLANK at layer 0, pending = 0. Reset mid-frame discards partial frame.
//  Frame format: SYNC_BYTE, then N*N*N/8 data bytes; byte k holds bits 8k..8k+7 of the
//   frame vector, LSB first; bit index = layer*N*N + row*N + col.
//  Loader FSM (a transfer = in_valid & in_ready):
//   L_SYNC: byte == SYNC_BYTE -> L_DATA, bidx = 0; other byte -> discard, sync_err pulse.
//   L_DATA: write byte to back buffer at bidx, bidx++; on last byte set pending,
//    go L_SYNC. No timeout; only sync resets bidx.
//   in_ready = !pending. While pending, no bytes accepted (incl. sync).
//  Scan FSM: S_BLANK (BLANK_CYCLES cycles) -> S_ON (LAYER_DWELL cycles) -> S_BLANK of
//   next layer; layer index wraps N-1 -> 0.
//   First cycle of S_BLANK: if layer == 0 and pending, swap front/back, clear pending
//   (in_ready = 1 next cycle), pulse frame_tick, frame_count++. Same cycle: col_out
//   registers front-buffer slice for that layer (post-swap slice if swap occurs).
//   layer_out = 0 throughout S_BLANK; = 1<<layer throughout S_ON. col_out stable in S_ON.
//   Layer period = BLANK_CYCLES + LAYER_DWELL; frame period = N * that.
//  Swap only at layer-0 entry: a frame never shows mixed old/new layers.
//  Simultaneous last-byte write and layer-0 entry: pending rises next cycle; swap
//   waits for the following layer-0 entry.
//  enable = 0: next cycle col_out = 0, layer_out = 0, scan forced to S_BLANK layer 0,
//   counter restarts; a pending swap occurs on the first cycle enable = 1 (entry to
//   layer 0). Loader keeps running while disabled.
//  Counters sized to $clog2(max(LAYER_DWELL, BLANK_CYCLES)+1); bidx to $clog2(N^3/8+1).
// TESTING  (N=4, LAYER_DWELL=10, BLANK_CYCLES=2; 8 bytes per frame)
//  Reset -> all outputs 0, in_ready=1; enable=1: layer_out 0001,0010,0100,1000 lit 10 cycles
//   each, 2 dark cycles between; col_out = 0.
//  Send A5, FF,00, 00,00, 00,00, 0F,F0 -> pending, in_ready=0; at next layer-0 entry
//   frame_tick pulse, frame_count=1; layer0 col_out=16'h00FF, layer3 col_out=16'hF00F.
//  Send 3C then A5 + 8 bytes -> sync_err one pulse, 3C ignored, frame loads normally.
//  Second full frame sent while first pending -> in_ready held 0 until swap; no byte lost,
//   second frame visible one scan frame later, frame_count=2.
//  Last data byte accepted while scan is mid-layer 2 -> layers 2,3 still old data; new
//   data from layer 0 onward (no tearing).
//  enable=0 during S_ON layer 1 -> next cycle outputs 0; enable=1 -> restart at layer 0 blank.
//  reset_n low mid-frame (after 3 data bytes) -> outputs 0; fresh A5 + 8 bytes loads cleanly.

Source files
------------

// File: rtl/led_cube_scan_driver.sv
// LED-cube scan driver: collects framed bytes from the UART RX stream into a
// double-buffered frame store and multiplexes the displayed frame onto the
// column/layer drive lines, one layer at a time with blanking between layers.
module led_cube_scan_driver #(
  parameter int          N            = 8,
  parameter int          LAYER_DWELL  = 50000,
  parameter int          BLANK_CYCLES = 500,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N-1:0]   col_out,
  output logic [N-1:0]     layer_out,
  output logic             frame_tick,
  output logic [7:0]       frame_count,
  output logic             sync_err
);

  localparam int NBYTES = N * N * N / 8;   // bytes per frame
  localparam int LBYTES = N * N / 8;       // bytes per layer slice
  localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int LW     = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX   = (LAYER_DWELL > BLANK_CYCLES) ? LAYER_DWELL : BLANK_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);

  typedef enum logic {L_SYNC, L_DATA} load_state_t;
  typedef enum logic {S_BLANK, S_ON}  scan_state_t;

  // Loader state
  load_state_t     r_lstate;
  load_state_t     w_lstate_next;
  logic [BW-1:0]   r_bidx;
  logic [BW-1:0]   w_bidx_next;
  logic            r_pending;
  logic            r_sync_err;
  logic            w_xfer;
  logic            w_wr_en;
  logic            w_last;
  logic            w_sync_err;

  // Frame store: two byte-wide buffers, r_front_sel picks the displayed one
  logic [7:0]      r_mem [2][NBYTES];
  logic            r_front_sel;
  logic            w_rd_sel;
  logic [AW-1:0]   w_base;
  logic [N*N-1:0]  w_slice;

  // Scan state
  scan_state_t     r_sstate;
  scan_state_t     w_sstate_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [LW-1:0]   r_layer;
  logic [LW-1:0]   w_layer_next;
  logic            w_blank_first;
  logic            w_swap;
  logic [N*N-1:0]  r_col;
  logic            r_tick;
  logic [7:0]      r_count;
  logic [N-1:0]    w_onehot;

  // No byte (not even a sync byte) is taken while a finished frame waits for its swap
  assign in_ready = ~r_pending;
  assign w_xfer   = in_valid & ~r_pending;

  // Loader next-state: hunt for sync, then count data bytes into the back buffer
  always_comb begin
    w_lstate_next = r_lstate;
    w_bidx_next   = r_bidx;
    w_wr_en       = 1'b0;
    w_last        = 1'b0;
    w_sync_err    = 1'b0;
    case (r_lstate)
      L_SYNC: begin
        if (w_xfer) begin
          if (in_data == SYNC_BYTE) begin
            w_lstate_next = L_DATA;
            w_bidx_next   = '0;
          end else begin
            w_sync_err = 1'b1;
          end
        end
      end
      L_DATA: begin
        if (w_xfer) begin
          w_wr_en     = 1'b1;
          w_bidx_next = r_bidx + BW'(1);
          if (r_bidx == BW'(NBYTES - 1)) begin
            w_last        = 1'b1;
            w_lstate_next = L_SYNC;
          end
        end
      end
      default: w_lstate_next = L_SYNC;
    endcase
  end

  // Loader state register and sync-error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lstate   <= L_SYNC;
      r_bidx     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_lstate   <= w_lstate_next;
      r_bidx     <= w_bidx_next;
      r_sync_err <= w_sync_err;
    end
  end

  // Pending flag: set by the last data byte, cleared by the swap (never both at once)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_last) begin
      r_pending <= 1'b1;
    end else if (w_swap) begin
      r_pending <= 1'b0;
    end
  end

  // Frame store writes go to the back buffer only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NBYTES; k++) begin
          r_mem[b][k] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_mem[~r_front_sel][AW'(r_bidx)] <= in_data;
    end
  end

  // Slice read selects the post-swap front buffer when a swap happens this cycle
  assign w_rd_sel = r_front_sel ^ w_swap;
  assign w_base   = AW'(LBYTES * int'(r_layer));

  genvar gi;
  generate
    for (gi = 0; gi < LBYTES; gi++) begin : g_slice
      assign w_slice[gi*8 +: 8] = r_mem[w_rd_sel][w_base + AW'(gi)];
    end
  endgenerate

  // Swap only on the first blank cycle of layer 0, so a scan frame is never mixed
  assign w_blank_first = (r_sstate == S_BLANK) && (r_cnt == '0);
  assign w_swap        = enable && w_blank_first && (r_layer == '0) && r_pending;

  // Scan next-state: blank -> on -> blank of next layer; disable parks at layer 0 blank
  always_comb begin
    w_sstate_next = r_sstate;
    w_cnt_next    = r_cnt;
    w_layer_next  = r_layer;
    if (!enable) begin
      w_sstate_next = S_BLANK;
      w_cnt_next    = '0;
      w_layer_next  = '0;
    end else begin
      case (r_sstate)
        S_BLANK: begin
          if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
            w_sstate_next = S_ON;
            w_cnt_next    = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_ON: begin
          if (r_cnt == CW'(LAYER_DWELL - 1)) begin
            w_sstate_next = S_BLANK;
            w_cnt_next    = '0;
            w_layer_next  = (r_layer == LW'(N - 1)) ? '0 : r_layer + LW'(1);
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: begin
          w_sstate_next = S_BLANK;
          w_cnt_next    = '0;
          w_layer_next  = '0;
        end
      endcase
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sstate <= S_BLANK;
      r_cnt    <= '0;
      r_layer  <= '0;
    end else begin
      r_sstate <= w_sstate_next;
      r_cnt    <= w_cnt_next;
      r_layer  <= w_layer_next;
    end
  end

  // Buffer swap, frame tick/count and column latch on layer entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_front_sel <= 1'b0;
      r_tick      <= 1'b0;
      r_count     <= '0;
      r_col       <= '0;
    end else begin
      r_tick  <= w_swap;
      r_count <= r_count + {7'd0, w_swap};
      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
      end
      if (!enable) begin
        r_col <= '0;
      end else if (w_blank_first) begin
        r_col <= w_slice;
      end
    end
  end

  assign w_onehot    = {{(N-1){1'b0}}, 1'b1} << r_layer;
  assign layer_out   = (r_sstate == S_ON) ? w_onehot : '0;
  assign col_out     = r_col;
  assign frame_tick  = r_tick;
  assign frame_count = r_count;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_led_cube_scan_driver.sv
// Randomised bench for led_cube_scan_driver (N=4, dwell 10, blank 2).
// The reference model tracks scan position arithmetically and the frame
// store as whole frame vectors; outputs are compared every cycle on negedge.
module tb_led_cube_scan_driver;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int BL = 2;
  localparam int LP = BL + DW;   // layer period
  localparam int FP = N * LP;    // frame period
  localparam int NB = N * N * N / 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*N-1:0]    col_out;
  logic [N-1:0]      layer_out;
  logic              frame_tick;
  logic [7:0]        frame_count;
  logic              sync_err;

  led_cube_scan_driver #(
    .N(N), .LAYER_DWELL(DW), .BLANK_CYCLES(BL), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .col_out(col_out), .layer_out(layer_out), .frame_tick(frame_tick),
    .frame_count(frame_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [NB*8-1:0] m_front, m_back;
  bit              m_pending, m_sync;
  int              m_k, m_t;
  logic [N*N-1:0]  m_col;
  bit              m_tick, m_serr;
  logic [7:0]      m_count;
  logic [7:0]      tx_q[$];
  int              dis_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = '0; m_back = '0; m_pending = 0; m_sync = 1; m_k = 0; m_t = 0;
    m_col = '0; m_tick = 0; m_serr = 0; m_count = '0;
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_layer;
    int idx;
    idx = (m_t / LP) % N;
    exp_layer = ((m_t % LP) >= BL) ? N'(1 << idx) : '0;
    check_eq("col_out",     col_out,     m_col);
    check_eq("layer_out",   layer_out,   exp_layer);
    check_eq("in_ready",    in_ready,    !m_pending);
    check_eq("frame_tick",  frame_tick,  m_tick);
    check_eq("frame_count", frame_count, m_count);
    check_eq("sync_err",    sync_err,    m_serr);
  endtask

  // Advance the model across one rising edge using the inputs just driven
  task automatic model_advance();
    bit xfer, swap;
    int layer;
    logic [NB*8-1:0] nf;
    xfer  = in_valid && !m_pending;
    swap  = enable && (m_t % FP == 0) && m_pending;
    layer = (m_t / LP) % N;
    nf    = swap ? m_back : m_front;
    if (!enable) m_col = '0;
    else if (m_t % LP == 0) m_col = nf[layer*N*N +: N*N];
    m_tick = swap;
    m_serr = xfer && m_sync && (in_data != 8'hA5);
    if (swap) begin
      m_count   = m_count + 8'd1;
      m_back    = m_front;
      m_front   = nf;
      m_pending = 0;
      $display("[TB] frame %0d visible: %h at %0t", m_count, nf, $time);
    end
    if (xfer) begin
      if (m_sync) begin
        if (in_data == 8'hA5) begin m_sync = 0; m_k = 0; end
      end else begin
        m_back[m_k*8 +: 8] = in_data;
        m_k++;
        if (m_k == NB) begin m_pending = 1; m_sync = 1; end
      end
      void'(tx_q.pop_front());
    end
    m_t = enable ? (m_t + 1) % FP : 0;
  endtask

  // One clock: check, drive next inputs, advance model, wait next negedge
  task automatic step();
    compare_outputs();
    enable = (dis_cnt == 0);
    if (dis_cnt > 0) dis_cnt--;
    if (tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      in_valid = 1'b1; in_data = tx_q[0];
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom);
    end
    model_advance();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while (tx_q.size() > 0 && c < limit) begin step(); c++; end
    if (tx_q.size() > 0) check_eq("drain_timeout", tx_q.size(), 0);
  endtask

  task automatic push_frame(input logic [NB*8-1:0] f);
    tx_q.push_back(8'hA5);
    for (int k = 0; k < NB; k++) tx_q.push_back(f[k*8 +: 8]);
  endtask

  function automatic logic [NB*8-1:0] rand_frame();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; dis_cnt = 0; tx_q.delete();
    model_reset();
    #1 compare_outputs();
    @(negedge clk);
    compare_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    reset_n = 1'b1;
    run(FP + 10);

    // Directed frame: layer 0 = 00FF, layer 3 = F00F
    push_frame(64'hF00F_0000_0000_00FF);
    drain(200);
    run(2 * FP);
    check_eq("count_after_first", frame_count, 8'd1);

    // Stray byte before sync, then a good frame
    tx_q.push_back(8'h3C);
    push_frame(rand_frame());
    drain(200);
    run(2 * FP);
    check_eq("count_after_second", frame_count, 8'd2);

    // Two frames back to back: second held off by backpressure
    push_frame(rand_frame());
    push_frame(rand_frame());
    drain(400);
    run(2 * FP);
    check_eq("count_after_pair", frame_count, 8'd4);

    // Disable while layer 1 is lit
    for (int c = 0; c < FP && m_t != LP + BL + 3; c++) step();
    check_eq("reach_layer1_on", m_t, LP + BL + 3);
    dis_cnt = 3;
    run(FP + 5);

    // Random frames with occasional junk bytes and enable drops
    for (int it = 0; it < 40; it++) begin
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) tx_q.push_back(8'($urandom));
      push_frame(rand_frame());
      if ($urandom_range(0, 3) == 0) dis_cnt = $urandom_range(1, 30);
      drain(800);
      run($urandom_range(0, 60));
    end

    // Reset part way through a frame, then load cleanly
    dis_cnt = 0;
    run(2 * FP + 10);
    tx_q.push_back(8'hA5);
    for (int j = 0; j < 3; j++) tx_q.push_back(8'($urandom));
    drain(100);
    run(3);
    do_reset();
    push_frame(rand_frame());
    drain(200);
    run(2 * FP);
    check_eq("count_after_reset", frame_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
